// File: rtl/bp_tlb_walk_arbiter.sv
// -----------------------------------------------------------------------------
// bp_tlb_walk_arbiter
//
// Purpose:
//   Shares one page-table walker between the I-TLB and D-TLB miss paths.
//   Each TLB's single-cycle miss pulse and vtag are captured in a pending
//   bit/vtag register pair. The walker is granted round-robin. The walk is
//   issued with a valid/ready handshake, and the leaf PTE that comes back is
//   written into the requesting TLB as a one-cycle fill.
//
// Parameters:
//   vtag_width_p   virtual tag width (TLB vtag / miss vtag)
//   entry_width_p  leaf PTE entry width (TLB fill entry)
//
// Ports:
//   clk_i             clock
//   reset_n_i         asynchronous active-low reset
//   flush_i           sfence/ASID flush: cancels queued and in-flight fills
//   itlb_miss_v_i     I-TLB miss pulse      itlb_miss_vtag_i  I-TLB miss vtag
//   dtlb_miss_v_i     D-TLB miss pulse      dtlb_miss_vtag_i  D-TLB miss vtag
//   walk_v_o          walk request valid    walk_vtag_o       vtag to walk
//   walk_ready_i      PTW accepts request
//   walk_v_i          PTW response pulse    walk_entry_i      leaf PTE
//   walk_fault_i      PTW page fault on this response
//   itlb_w_v_o        I-TLB fill write      dtlb_w_v_o        D-TLB fill write
//   fill_vtag_o       fill vtag (shared)    fill_entry_o      fill entry (shared)
//   fault_v_o         fault report pulse    fault_dtlb_o      1 = D-TLB source
//   busy_o            FSM not idle, or a request is pending
//
// Configuration macro:
//   BP_TLB_WALK_ARB_FAULT_EN  when defined, a faulting response produces a
//   one-cycle fault_v_o pulse instead of a fill. When undefined, walk_fault_i
//   is ignored and fault_v_o/fault_dtlb_o are tied low.
//
// Requester index 0 is the I-TLB, index 1 is the D-TLB.
// -----------------------------------------------------------------------------
module bp_tlb_walk_arbiter #(
   parameter int vtag_width_p  = 28,
   parameter int entry_width_p = 34
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     flush_i,
   input  logic                     itlb_miss_v_i,
   input  logic [vtag_width_p-1:0]  itlb_miss_vtag_i,
   input  logic                     dtlb_miss_v_i,
   input  logic [vtag_width_p-1:0]  dtlb_miss_vtag_i,
   output logic                     walk_v_o,
   output logic [vtag_width_p-1:0]  walk_vtag_o,
   input  logic                     walk_ready_i,
   input  logic                     walk_v_i,
   input  logic [entry_width_p-1:0] walk_entry_i,
   input  logic                     walk_fault_i,
   output logic                     itlb_w_v_o,
   output logic                     dtlb_w_v_o,
   output logic [vtag_width_p-1:0]  fill_vtag_o,
   output logic [entry_width_p-1:0] fill_entry_o,
   output logic                     fault_v_o,
   output logic                     fault_dtlb_o,
   output logic                     busy_o
);

   typedef enum logic [1:0] {
      IDLE_S = 2'd0,
      SEND_S = 2'd1,
      WAIT_S = 2'd2,
      FILL_S = 2'd3
   } state_e;

   state_e                   state_reg, state_next;

   // per-requester capture
   logic [1:0]               pending_reg, pending_next;
   logic [vtag_width_p-1:0]  vtag_reg  [2];
   logic [vtag_width_p-1:0]  vtag_next [2];

   // walk in progress
   logic                     cur_dtlb_reg, cur_dtlb_next;
   logic                     last_grant_reg, last_grant_next;
   logic                     drop_reg, drop_next;
   logic [vtag_width_p-1:0]  walk_vtag_reg, walk_vtag_next;
   logic [entry_width_p-1:0] entry_reg, entry_next;

   // request / grant plumbing
   logic [1:0]               miss_v;
   logic [vtag_width_p-1:0]  miss_vtag [2];
   logic [1:0]               pulse_ok;
   logic [1:0]               req;
   logic [1:0]               pick;
   logic [1:0]               grant;
   logic [vtag_width_p-1:0]  grant_vtag;
   logic                     walking;
   logic                     grant_cycle;
   logic                     fault_hit;

   assign miss_v       = {dtlb_miss_v_i, itlb_miss_v_i};
   assign miss_vtag[0] = itlb_miss_vtag_i;
   assign miss_vtag[1] = dtlb_miss_vtag_i;

   assign walking      = (state_reg != IDLE_S);
   // A flush in IDLE wipes everything, so no grant is made in that cycle.
   assign grant_cycle  = (state_reg == IDLE_S) & ~flush_i;

   // --------------------------------------------------------------------------
   // Per-requester capture. A pulse is dropped when it coincides with a flush
   // or when its requester is the one currently owning the walker (the TLB
   // will re-miss after the fill if it still needs to). An accepted pulse
   // always reloads the vtag, so a second miss before the grant replaces the
   // first.
   // --------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         localparam logic req_id = (gi == 1);

         assign pulse_ok[gi]     = miss_v[gi] & ~flush_i
                                 & ~(walking & (cur_dtlb_reg == req_id));
         // A pulse in the grant cycle competes immediately (bypass).
         assign req[gi]          = pending_reg[gi] | pulse_ok[gi];
         assign grant[gi]        = grant_cycle & pick[gi];
         assign pending_next[gi] = ~flush_i & ~grant[gi]
                                 & (pulse_ok[gi] | pending_reg[gi]);
         assign vtag_next[gi]    = pulse_ok[gi] ? miss_vtag[gi] : vtag_reg[gi];
      end
   endgenerate

   // Round-robin: with both requesting, the one not granted last time wins.
   always_comb begin
      pick = req;
      if (&req) begin
         pick = last_grant_reg ? 2'b01 : 2'b10;
      end
   end

   // vtag_next already carries the bypassed vtag when a pulse arrives now.
   assign grant_vtag = grant[1] ? vtag_next[1] : vtag_next[0];

   // --------------------------------------------------------------------------
   // Fault qualification
   // --------------------------------------------------------------------------
`ifdef BP_TLB_WALK_ARB_FAULT_EN
   logic fault_v_reg;
   logic fault_dtlb_reg;

   assign fault_hit = walk_fault_i;

   // Registered so the fault report lands in the slot a fill would have used.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fault_v_reg    <= 1'b0;
         fault_dtlb_reg <= 1'b0;
      end else begin
         fault_v_reg    <= (state_reg == WAIT_S) & walk_v_i & ~drop_reg
                         & ~flush_i & walk_fault_i;
         fault_dtlb_reg <= (state_reg == WAIT_S) & walk_v_i & ~drop_reg
                         & ~flush_i & walk_fault_i & cur_dtlb_reg;
      end
   end

   assign fault_v_o    = fault_v_reg;
   assign fault_dtlb_o = fault_dtlb_reg;
`else
   logic unused_walk_fault;

   assign unused_walk_fault = walk_fault_i;
   assign fault_hit         = 1'b0;
   assign fault_v_o         = 1'b0;
   assign fault_dtlb_o      = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // FSM next state and outputs
   // --------------------------------------------------------------------------
   always_comb begin
      state_next      = state_reg;
      cur_dtlb_next   = cur_dtlb_reg;
      last_grant_next = last_grant_reg;
      drop_next       = drop_reg;
      walk_vtag_next  = walk_vtag_reg;
      entry_next      = entry_reg;
      walk_v_o        = 1'b0;
      itlb_w_v_o      = 1'b0;
      dtlb_w_v_o      = 1'b0;

      case (state_reg)
         IDLE_S: begin
            if (|grant) begin
               cur_dtlb_next   = grant[1];
               last_grant_next = grant[1];
               walk_vtag_next  = grant_vtag;
               drop_next       = 1'b0;
               state_next      = SEND_S;
            end
         end

         SEND_S: begin
            walk_v_o = 1'b1;
            if (walk_ready_i) begin
               // The PTW has the request even if a flush arrives with it, so
               // its response must still be consumed, just not used.
               state_next = WAIT_S;
               drop_next  = flush_i;
            end else if (flush_i) begin
               state_next = IDLE_S;
            end
         end

         WAIT_S: begin
            if (walk_v_i) begin
               state_next = IDLE_S;
               drop_next  = 1'b0;
               if (!(drop_reg | flush_i) && !fault_hit) begin
                  entry_next = walk_entry_i;
                  state_next = FILL_S;
               end
            end else if (flush_i) begin
               drop_next = 1'b1;
            end
         end

         FILL_S: begin
            itlb_w_v_o = ~flush_i & ~cur_dtlb_reg;
            dtlb_w_v_o = ~flush_i &  cur_dtlb_reg;
            state_next = IDLE_S;
         end

         default: begin
            state_next = IDLE_S;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_reg      <= IDLE_S;
         pending_reg    <= 2'b00;
         vtag_reg[0]    <= '0;
         vtag_reg[1]    <= '0;
         cur_dtlb_reg   <= 1'b0;
         // "D-TLB granted last" so the I-TLB wins the first contested grant.
         last_grant_reg <= 1'b1;
         drop_reg       <= 1'b0;
         walk_vtag_reg  <= '0;
         entry_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         pending_reg    <= pending_next;
         vtag_reg[0]    <= vtag_next[0];
         vtag_reg[1]    <= vtag_next[1];
         cur_dtlb_reg   <= cur_dtlb_next;
         last_grant_reg <= last_grant_next;
         drop_reg       <= drop_next;
         walk_vtag_reg  <= walk_vtag_next;
         entry_reg      <= entry_next;
      end
   end

   // walk_vtag_reg only changes on a grant, so it is stable through SEND and
   // still describes the walked page during FILL.
   assign walk_vtag_o  = walk_vtag_reg;
   assign fill_vtag_o  = walk_vtag_reg;
   assign fill_entry_o = entry_reg;
   assign busy_o       = walking | (|pending_reg);

`ifndef SYNTHESIS
   // The PTW only answers a request it accepted; a response in any other
   // state means the walker and the arbiter disagree about who owns it.
   resp_only_in_wait_a : assert property (
      @(posedge clk_i) disable iff (!reset_n_i)
      walk_v_i |-> (state_reg == WAIT_S));
`endif

endmodule

// File: tb/tb_bp_tlb_walk_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bp_tlb_walk_arbiter
//
// Self-checking bench. A transaction-level model (pending requests, one
// transaction record, a queued fill/fault slot) predicts the outputs every
// cycle. Directed scenarios pin the model with literal expectations, and a
// long random run follows. A small PTW model answers accepted walks after a
// chosen latency.
// -----------------------------------------------------------------------------
module tb_bp_tlb_walk_arbiter;

   localparam int VW = 28;
   localparam int EW = 34;

`ifdef BP_TLB_WALK_ARB_FAULT_EN
   localparam bit FAULT_EN = 1'b1;
`else
   localparam bit FAULT_EN = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          reset_n_i;
   logic          flush_i;
   logic          itlb_miss_v_i;
   logic [VW-1:0] itlb_miss_vtag_i;
   logic          dtlb_miss_v_i;
   logic [VW-1:0] dtlb_miss_vtag_i;
   logic          walk_v_o;
   logic [VW-1:0] walk_vtag_o;
   logic          walk_ready_i;
   logic          walk_v_i;
   logic [EW-1:0] walk_entry_i;
   logic          walk_fault_i;
   logic          itlb_w_v_o;
   logic          dtlb_w_v_o;
   logic [VW-1:0] fill_vtag_o;
   logic [EW-1:0] fill_entry_o;
   logic          fault_v_o;
   logic          fault_dtlb_o;
   logic          busy_o;

   always #5 clk_i = ~clk_i;

   bp_tlb_walk_arbiter #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
      .clk_i            (clk_i),
      .reset_n_i        (reset_n_i),
      .flush_i          (flush_i),
      .itlb_miss_v_i    (itlb_miss_v_i),
      .itlb_miss_vtag_i (itlb_miss_vtag_i),
      .dtlb_miss_v_i    (dtlb_miss_v_i),
      .dtlb_miss_vtag_i (dtlb_miss_vtag_i),
      .walk_v_o         (walk_v_o),
      .walk_vtag_o      (walk_vtag_o),
      .walk_ready_i     (walk_ready_i),
      .walk_v_i         (walk_v_i),
      .walk_entry_i     (walk_entry_i),
      .walk_fault_i     (walk_fault_i),
      .itlb_w_v_o       (itlb_w_v_o),
      .dtlb_w_v_o       (dtlb_w_v_o),
      .fill_vtag_o      (fill_vtag_o),
      .fill_entry_o     (fill_entry_o),
      .fault_v_o        (fault_v_o),
      .fault_dtlb_o     (fault_dtlb_o),
      .busy_o           (busy_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // stimulus for the next cycle
   bit            s_imiss, s_dmiss, s_flush, s_ready, s_fault;
   logic [VW-1:0] s_ivtag, s_dvtag;
   logic [EW-1:0] s_entry;
   int            s_lat;

   // model: waiting requests, the owning transaction, result slots
   bit            m_pend [2];
   logic [VW-1:0] m_pvtag [2];
   int            m_last;
   bit            m_active, m_sent, m_drop;
   int            m_who;
   logic [VW-1:0] m_vtag;
   bit            m_fill;
   logic [EW-1:0] m_fill_entry;
   bit            m_fault;
   int            m_fault_who;
   int            resp_cnt;

   bit            obs_walk_v, obs_busy, obs_resp;

   typedef struct {
      bit            dtlb;
      logic [VW-1:0] vtag;
      logic [EW-1:0] entry;
      int            cyc;
   } fill_t;

   fill_t         fills [$];
   bit            faults [$];
   logic [VW-1:0] hs_log [$];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit model_idle();
      return !m_active && !m_fill && !m_fault && !m_pend[0] && !m_pend[1];
   endfunction

   task automatic model_reset();
      m_pend[0] = 0; m_pend[1] = 0;
      m_pvtag[0] = '0; m_pvtag[1] = '0;
      m_last = 1;
      m_active = 0; m_sent = 0; m_drop = 0; m_who = 0;
      m_vtag = '0;
      m_fill = 0; m_fill_entry = '0;
      m_fault = 0; m_fault_who = 0;
      resp_cnt = 0;
   endtask

   task automatic clear_stim();
      s_imiss = 0; s_dmiss = 0; s_flush = 0; s_ready = 0; s_fault = 0;
      s_ivtag = '0; s_dvtag = '0; s_entry = '0; s_lat = 0;
   endtask

   task automatic do_reset();
      reset_n_i = 1'b0;
      flush_i = 0; itlb_miss_v_i = 0; dtlb_miss_v_i = 0;
      itlb_miss_vtag_i = '0; dtlb_miss_vtag_i = '0;
      walk_ready_i = 0; walk_v_i = 0; walk_entry_i = '0; walk_fault_i = 0;
      repeat (2) begin
         @(negedge clk_i);
         chk("rst_walk_v", walk_v_o, 0);
         chk("rst_walk_vtag", walk_vtag_o, 0);
         chk("rst_itlb_w", itlb_w_v_o, 0);
         chk("rst_dtlb_w", dtlb_w_v_o, 0);
         chk("rst_fault_v", fault_v_o, 0);
         chk("rst_busy", busy_o, 0);
      end
      model_reset();
      clear_stim();
      @(posedge clk_i);
      #1 reset_n_i = 1'b1;
   endtask

   // Outputs the specification's rules demand for the current model state
   // and the inputs applied this cycle.
   task automatic check_outputs();
      bit exp_iw, exp_dw;
      exp_iw = m_fill && (m_who == 0) && !s_flush;
      exp_dw = m_fill && (m_who == 1) && !s_flush;
      chk("walk_v", walk_v_o, m_active && !m_sent);
      chk("walk_vtag", walk_vtag_o, m_vtag);
      chk("itlb_w", itlb_w_v_o, exp_iw);
      chk("dtlb_w", dtlb_w_v_o, exp_dw);
      if (exp_iw || exp_dw) begin
         chk("fill_vtag", fill_vtag_o, m_vtag);
         chk("fill_entry", fill_entry_o, m_fill_entry);
      end
      chk("fault_v", fault_v_o, m_fault);
      chk("fault_dtlb", fault_dtlb_o, m_fault && (m_fault_who == 1));
      chk("busy", busy_o, m_active || m_fill || m_pend[0] || m_pend[1]);
   endtask

   task automatic model_step();
      bit            idle0, acc [2], miss [2], n_fill, n_fault, c0, c1;
      logic [VW-1:0] mv [2];
      int            pick;
      idle0 = !m_active && !m_fill;
      miss[0] = s_imiss; miss[1] = s_dmiss;
      mv[0] = s_ivtag;   mv[1] = s_dvtag;
      for (int r = 0; r < 2; r++)
         acc[r] = miss[r] && !s_flush && !(!idle0 && (m_who == r));
      n_fill = 0; n_fault = 0; pick = -1;
      if (idle0) begin
         if (!s_flush) begin
            c0 = m_pend[0] || acc[0];
            c1 = m_pend[1] || acc[1];
            if (c0 && c1)  pick = (m_last == 0) ? 1 : 0;
            else if (c0)   pick = 0;
            else if (c1)   pick = 1;
            if (pick >= 0) begin
               m_active = 1; m_sent = 0; m_drop = 0; m_who = pick;
               m_vtag = acc[pick] ? mv[pick] : m_pvtag[pick];
               m_last = pick;
            end
         end
      end else if (m_fill) begin
         m_fill = 0;
      end else if (!m_sent) begin
         if (s_ready) begin
            m_sent = 1; m_drop = s_flush; resp_cnt = s_lat;
         end else if (s_flush) begin
            m_active = 0;
         end
      end else begin
         if (walk_v_i) begin
            m_active = 0;
            if (!(m_drop || s_flush)) begin
               if (FAULT_EN && walk_fault_i) begin
                  n_fault = 1; m_fault_who = m_who;
               end else begin
                  n_fill = 1; m_fill_entry = walk_entry_i;
               end
            end
         end else if (s_flush) begin
            m_drop = 1;
         end
      end
      for (int r = 0; r < 2; r++) begin
         if (pick == r) m_pend[r] = 0;
         else if (acc[r]) begin m_pend[r] = 1; m_pvtag[r] = mv[r]; end
         if (s_flush) m_pend[r] = 0;
      end
      if (n_fill) m_fill = 1;
      m_fault = n_fault;
   endtask

   task automatic cycle();
      bit          resp;
      logic [63:0] r;
      @(posedge clk_i);
      #1;
      itlb_miss_v_i = s_imiss; itlb_miss_vtag_i = s_ivtag;
      dtlb_miss_v_i = s_dmiss; dtlb_miss_vtag_i = s_dvtag;
      flush_i = s_flush; walk_ready_i = s_ready;
      r = {$urandom, $urandom};
      walk_entry_i = r[EW-1:0];
      walk_fault_i = 1'($urandom_range(0, 1));
      walk_v_i = 0; resp = 0;
      if (m_active && m_sent) begin
         if (resp_cnt == 0) begin
            resp = 1; walk_v_i = 1; walk_entry_i = s_entry; walk_fault_i = s_fault;
         end else begin
            resp_cnt--;
         end
      end
      @(negedge clk_i);
      check_outputs();
      obs_walk_v = walk_v_o; obs_busy = busy_o; obs_resp = resp;
      if (walk_v_o && walk_ready_i) begin
         hs_log.push_back(walk_vtag_o);
         $display("cycle %0d: walk vtag=0x%0h", cyc, walk_vtag_o);
      end
      if (itlb_w_v_o || dtlb_w_v_o) begin
         fills.push_back('{dtlb_w_v_o, fill_vtag_o, fill_entry_o, cyc});
         $display("cycle %0d: fill %s vtag=0x%0h entry=0x%0h", cyc,
                  dtlb_w_v_o ? "dtlb" : "itlb", fill_vtag_o, fill_entry_o);
      end
      if (fault_v_o) begin
         faults.push_back(fault_dtlb_o);
         $display("cycle %0d: fault dtlb=%0d", cyc, fault_dtlb_o);
      end
      model_step();
      cyc++;
      s_imiss = 0; s_dmiss = 0; s_flush = 0;
   endtask

   task automatic drain(int max_cycles);
      int n = 0;
      while (!model_idle() && n < max_cycles) begin
         cycle();
         n++;
      end
      checks++;
      if (!model_idle()) begin
         errors++;
         $display("FAIL drain_timeout: still busy after %0d cycles", max_cycles);
      end
   endtask

   task automatic clear_logs();
      fills.delete(); faults.delete(); hs_log.delete();
   endtask

   initial begin
      int            miss_cyc;
      logic [63:0]   r;
      bit            got_resp;

      reset_n_i = 1'b0;
      clear_stim();
      model_reset();

      // 1: single I-TLB miss, PTW answers two cycles after accepting
      do_reset();
      clear_logs();
      s_ready = 1; s_lat = 1; s_entry = 34'hABC;
      s_imiss = 1; s_ivtag = 28'h123;
      miss_cyc = cyc;
      cycle();
      drain(20);
      chk("t1_walk_count", hs_log.size(), 1);
      if (hs_log.size() > 0) chk("t1_walk_vtag", hs_log[0], 28'h123);
      chk("t1_fill_count", fills.size(), 1);
      if (fills.size() > 0) begin
         chk("t1_fill_dtlb", fills[0].dtlb, 0);
         chk("t1_fill_vtag", fills[0].vtag, 28'h123);
         chk("t1_fill_entry", fills[0].entry, 34'hABC);
         chk("t1_latency", fills[0].cyc - miss_cyc, 4);
      end

      // 2: simultaneous misses; round-robin order and back-to-back grants
      do_reset();
      clear_logs();
      s_ready = 1; s_lat = 0; s_entry = 34'h111;
      s_imiss = 1; s_ivtag = 28'h10; s_dmiss = 1; s_dvtag = 28'h20;
      miss_cyc = cyc;
      cycle();
      drain(30);
      s_imiss = 1; s_ivtag = 28'h60;
      cycle();
      drain(30);
      s_imiss = 1; s_ivtag = 28'h40; s_dmiss = 1; s_dvtag = 28'h50;
      cycle();
      drain(30);
      chk("t2_fill_count", fills.size(), 5);
      if (fills.size() == 5) begin
         chk("t2_first_dtlb", fills[0].dtlb, 0);
         chk("t2_first_vtag", fills[0].vtag, 28'h10);
         chk("t2_min_latency", fills[0].cyc - miss_cyc, 3);
         chk("t2_second_dtlb", fills[1].dtlb, 1);
         chk("t2_second_vtag", fills[1].vtag, 28'h20);
         chk("t2_back_to_back", fills[1].cyc - fills[0].cyc, 4);
         chk("t2_pair2_first_dtlb", fills[3].dtlb, 1);
         chk("t2_pair2_first_vtag", fills[3].vtag, 28'h50);
         chk("t2_pair2_second_dtlb", fills[4].dtlb, 0);
         chk("t2_pair2_second_vtag", fills[4].vtag, 28'h40);
      end

      // 3: D-TLB re-miss before its grant replaces the queued vtag
      do_reset();
      clear_logs();
      s_ready = 1; s_lat = 3; s_entry = 34'h222;
      s_imiss = 1; s_ivtag = 28'h7;
      cycle();
      s_dmiss = 1; s_dvtag = 28'h30;
      cycle();
      s_dmiss = 1; s_dvtag = 28'h31;
      cycle();
      drain(40);
      chk("t3_walk_count", hs_log.size(), 2);
      if (hs_log.size() == 2) chk("t3_d_walk_vtag", hs_log[1], 28'h31);
      chk("t3_fill_count", fills.size(), 2);
      if (fills.size() == 2) chk("t3_d_fill_vtag", fills[1].vtag, 28'h31);

      // 4: flush while waiting; response is swallowed
      do_reset();
      clear_logs();
      s_ready = 1; s_lat = 3; s_entry = 34'h333;
      s_imiss = 1; s_ivtag = 28'h44;
      cycle();
      cycle();
      s_flush = 1;
      cycle();
      got_resp = 0;
      for (int i = 0; i < 10 && !got_resp; i++) begin
         cycle();
         got_resp = obs_resp;
      end
      chk("t4_response_seen", got_resp, 1);
      cycle();
      chk("t4_busy_after", obs_busy, 0);
      chk("t4_no_fill", fills.size(), 0);

      // 5: flush in SEND without handshake aborts the request
      do_reset();
      clear_logs();
      s_ready = 0; s_lat = 0;
      s_imiss = 1; s_ivtag = 28'h55;
      cycle();
      s_flush = 1;
      cycle();
      chk("t5_walk_v_in_send", obs_walk_v, 1);
      cycle();
      chk("t5_walk_v_dropped", obs_walk_v, 0);
      chk("t5_busy", obs_busy, 0);
      repeat (4) cycle();
      chk("t5_no_handshake", hs_log.size(), 0);
      chk("t5_no_fill", fills.size(), 0);

      // 6: faulting D-TLB walk
      do_reset();
      clear_logs();
      s_ready = 1; s_lat = 0; s_entry = 34'h2_0000_1234; s_fault = 1;
      s_dmiss = 1; s_dvtag = 28'h66;
      cycle();
      drain(20);
      if (FAULT_EN) begin
         chk("t6_fault_count", faults.size(), 1);
         if (faults.size() == 1) chk("t6_fault_dtlb", faults[0], 1);
         chk("t6_no_fill", fills.size(), 0);
      end else begin
         chk("t6_fault_count", faults.size(), 0);
         chk("t6_fill_count", fills.size(), 1);
         if (fills.size() == 1) begin
            chk("t6_fill_dtlb", fills[0].dtlb, 1);
            chk("t6_fill_entry", fills[0].entry, 34'h2_0000_1234);
         end
      end

      // random traffic against the model
      do_reset();
      clear_logs();
      for (int i = 0; i < 4000; i++) begin
         s_imiss = ($urandom_range(0, 4) == 0);
         s_dmiss = ($urandom_range(0, 4) == 0);
         s_ivtag = VW'($urandom);
         s_dvtag = VW'($urandom);
         s_ready = ($urandom_range(0, 2) != 0);
         s_flush = ($urandom_range(0, 24) == 0);
         s_lat   = int'($urandom_range(0, 3));
         s_fault = ($urandom_range(0, 2) == 0);
         r = {$urandom, $urandom};
         s_entry = r[EW-1:0];
         cycle();
      end
      s_ready = 1;
      drain(100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
